fifo_ptr_ctrl: RTL and testbench
================================

FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

Interface
REQ-001 Parameter DEPTH, default 16: number of FIFO entries; SHALL equal 2**PTR_WIDTH.
REQ-002 Parameter PTR_WIDTH, default 4: memory address width.
REQ-003 Parameter AF_LEVEL, default 12: almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 4: almost_empty asserts when count <= AE_LEVEL.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 wr_req  in  1  producer write request.
REQ-008 rd_req  in  1  consumer read request.
REQ-009 clr_err  in  1  clears the sticky overflow and underflow flags.
REQ-010 wen  out  1  write enable to the storage array.
REQ-011 ren  out  1  read enable to the storage array.
REQ-012 wptr  out  PTR_WIDTH  write address to the storage array.
REQ-013 rptr  out  PTR_WIDTH  read address to the storage array.
REQ-014 full  out  1  FIFO holds DEPTH entries.
REQ-015 empty  out  1  FIFO holds 0 entries.
REQ-016 almost_full  out  1  count >= AF_LEVEL.
REQ-017 almost_empty  out  1  count <= AE_LEVEL.
REQ-018 count  out  PTR_WIDTH+1  current occupancy, from 0 to DEPTH.
REQ-019 rd_valid  out  1  storage read data is valid this cycle.
REQ-020 overflow  out  1  sticky flag: a write was attempted while full.
REQ-021 underflow  out  1  sticky flag: a read was attempted while empty.

Function
REQ-022 The block SHALL keep internal write and read pointers of PTR_WIDTH+1 bits; the MSB is the wrap bit and the lower PTR_WIDTH bits drive wptr/rptr.
REQ-023 wen SHALL be combinational: wr_req & ~full.
REQ-024 ren SHALL be combinational: rd_req & ~empty.
REQ-025 On the clock edge where wen=1, the write pointer SHALL increment by 1, modulo 2**(PTR_WIDTH+1).
REQ-026 On the clock edge where ren=1, the read pointer SHALL increment by 1, modulo 2**(PTR_WIDTH+1).
REQ-027 wptr/rptr SHALL wrap from DEPTH-1 to 0 with no gap cycle; the wrap bit SHALL toggle at that edge.
REQ-028 empty SHALL be 1 when the full-width pointers are equal.
REQ-029 full SHALL be 1 when the wrap bits differ and the lower PTR_WIDTH bits are equal.
REQ-030 full and empty SHALL be decoded from registered pointers only, never from wr_req or rd_req.
REQ-031 count SHALL equal write pointer minus read pointer, computed modulo 2**(PTR_WIDTH+1).
REQ-032 almost_full and almost_empty SHALL be decoded from count.
REQ-033 Simultaneous wr_req and rd_req when neither full nor empty: both accepted, count unchanged.
REQ-034 Simultaneous wr_req and rd_req when full: read accepted, write rejected; the next cycle count=DEPTH-1.
REQ-035 Simultaneous wr_req and rd_req when empty: write accepted, read rejected; the next cycle count=1.
REQ-036 rd_valid SHALL be a register loaded with ren every cycle, giving one-cycle read latency that matches the registered storage output.
REQ-037 overflow SHALL set on any edge where wr_req & full; underflow SHALL set on any edge where rd_req & empty.
REQ-038 clr_err SHALL clear both sticky flags; if a set condition and clr_err occur on the same edge, the set SHALL win.
REQ-039 A rejected request SHALL NOT move any pointer or change count.

Reset
REQ-040 While rst_n=0, immediately and regardless of clk: both pointers=0, rd_valid=0, overflow=0, underflow=0.
REQ-041 The resulting outputs during reset SHALL be empty=1, full=0, count=0, almost_empty=1, almost_full=0, wen=0, ren=0.
REQ-042 Reset asserted mid-operation SHALL discard all occupancy; the FIFO SHALL come out of reset empty.
REQ-043 The first request SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-044 Scenario: 16 back-to-back wr_req from reset -> wptr 0..15, count 16, full=1, almost_full=1 from count 12, overflow=0.
REQ-045 Scenario: full, then wr_req for 1 cycle -> wen=0, wptr unchanged, overflow=1; then clr_err -> overflow=0.
REQ-046 Scenario: empty, then rd_req -> ren=0, underflow=1, rd_valid stays 0.
REQ-047 Scenario: 20 writes and 20 reads interleaved -> wptr/rptr wrap 15->0, wrap bit toggles, count correct every cycle, rd_valid high exactly one cycle after each ren.
REQ-048 Scenario: full with wr_req=rd_req=1 -> ren=1, wen=0, next count=15; empty with both requests -> wen=1, ren=0, next count=1.
REQ-049 Scenario: count=9, rst_n pulsed low between clock edges -> outputs reach reset values asynchronously, count=0, empty=1.

Source files
------------

// File: rtl/fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctrl
//
// Pointer, flag and handshake controller for a single-clock FIFO whose data
// lives in an external storage array with a registered (one-cycle) read port.
// The block owns the write/read addresses, occupancy count, threshold flags
// and sticky error flags; it never touches the data itself.
//
// Parameters
//   DEPTH      number of entries, must equal 2**PTR_WIDTH
//   PTR_WIDTH  storage address width
//   AF_LEVEL   almost_full  when count >= AF_LEVEL
//   AE_LEVEL   almost_empty when count <= AE_LEVEL
//
// Ports
//   clk           in   clock, all state changes on the rising edge
//   rst_n         in   asynchronous active-low reset
//   wr_req        in   producer write request
//   rd_req        in   consumer read request
//   clr_err       in   clears the sticky overflow/underflow flags
//   wen           out  storage write enable (accepted write this cycle)
//   ren           out  storage read enable (accepted read this cycle)
//   wptr          out  storage write address
//   rptr          out  storage read address
//   full          out  FIFO holds DEPTH entries
//   empty         out  FIFO holds no entries
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  occupancy 0..DEPTH
//   rd_valid      out  storage read data valid this cycle
//   overflow      out  sticky: write attempted while full
//   underflow     out  sticky: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_ptr_ctrl #(
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4,
    parameter int AF_LEVEL  = 12,
    parameter int AE_LEVEL  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_req,
    input  logic                 rd_req,
    input  logic                 clr_err,
    output logic                 wen,
    output logic                 ren,
    output logic [PTR_WIDTH-1:0] wptr,
    output logic [PTR_WIDTH-1:0] rptr,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 rd_valid,
    output logic                 overflow,
    output logic                 underflow
);

    // The wrap-bit scheme below only distinguishes full from empty when the
    // address space is exactly filled by the entries.
    generate
        if (DEPTH != (1 << PTR_WIDTH)) begin : g_bad_depth
            $error("fifo_ptr_ctrl: DEPTH must equal 2**PTR_WIDTH");
        end
    endgenerate

    localparam logic [PTR_WIDTH:0] AF_THR = AF_LEVEL[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AE_THR = AE_LEVEL[PTR_WIDTH:0];

    // Full-width pointers: MSB is the wrap bit, the rest is the address.
    logic [PTR_WIDTH:0] r_wr_ptr;
    logic [PTR_WIDTH:0] r_rd_ptr;
    logic               r_rd_valid;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_wen;
    logic               w_ren;
    logic [PTR_WIDTH:0] w_count;
    logic               w_ovf_set;
    logic               w_unf_set;

    // Status is decoded purely from the registered pointers so that the
    // request inputs never reach full/empty combinationally.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_WIDTH] != r_rd_ptr[PTR_WIDTH]) &&
                     (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0]);

    // Modulo subtraction of the full-width pointers yields 0..DEPTH directly.
    assign w_count = r_wr_ptr - r_rd_ptr;

    // Enables are masked while reset is held so the storage array sees no
    // strobes even if a requester is already active during reset.
    assign w_wen = wr_req & ~w_full  & rst_n;
    assign w_ren = rd_req & ~w_empty & rst_n;

    assign w_ovf_set = wr_req & w_full;
    assign w_unf_set = rd_req & w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wen) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_ren) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Tracks the registered read port of the storage array.
            r_rd_valid  <= w_ren;
            // A new error on the same edge as clr_err must not be lost.
            r_overflow  <= w_ovf_set | (r_overflow  & ~clr_err);
            r_underflow <= w_unf_set | (r_underflow & ~clr_err);
        end
    end

    assign wen          = w_wen;
    assign ren          = w_ren;
    assign wptr         = r_wr_ptr[PTR_WIDTH-1:0];
    assign rptr         = r_rd_ptr[PTR_WIDTH-1:0];
    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= AF_THR);
    assign almost_empty = (w_count <= AE_THR);
    assign rd_valid     = r_rd_valid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ptr_ctrl
//
// Directed bench for fifo_ptr_ctrl (default parameters). An occupancy-based
// reference model predicts every output; post-edge expectations are queued
// when a step is driven and popped after the clock edge it affects.
// -----------------------------------------------------------------------------
module tb_fifo_ptr_ctrl;

    localparam int DEPTH = 16;
    localparam int PW    = 4;
    localparam int AFL   = 12;
    localparam int AEL   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req, rd_req, clr_err;
    logic          wen, ren;
    logic [PW-1:0] wptr, rptr;
    logic          full, empty, almost_full, almost_empty;
    logic [PW:0]   count;
    logic          rd_valid, overflow, underflow;

    fifo_ptr_ctrl #(
        .DEPTH(DEPTH), .PTR_WIDTH(PW), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .rd_req(rd_req), .clr_err(clr_err),
        .wen(wen), .ren(ren), .wptr(wptr), .rptr(rptr),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .rd_valid(rd_valid),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rv;
        logic [PW-1:0] wp;
        logic [PW-1:0] rp;
        logic [PW:0]   cnt;
        logic          fl;
        logic          em;
        logic          af;
        logic          ae;
        logic          ov;
        logic          un;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: occupancy counter plus free-running addresses.
    int m_cnt = 0;
    int m_wa  = 0;
    int m_ra  = 0;
    bit m_ov  = 0;
    bit m_un  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model_now(input bit rv);
        exp_t e;
        e.rv  = rv;
        e.wp  = PW'(m_wa);
        e.rp  = PW'(m_ra);
        e.cnt = (PW+1)'(m_cnt);
        e.fl  = (m_cnt == DEPTH);
        e.em  = (m_cnt == 0);
        e.af  = (m_cnt >= AFL);
        e.ae  = (m_cnt <= AEL);
        e.ov  = m_ov;
        e.un  = m_un;
        return e;
    endfunction

    task automatic chk_state(input string tag, input exp_t e);
        chk({tag, ".rd_valid"},     rd_valid,     e.rv);
        chk({tag, ".wptr"},         wptr,         e.wp);
        chk({tag, ".rptr"},         rptr,         e.rp);
        chk({tag, ".count"},        count,        e.cnt);
        chk({tag, ".full"},         full,         e.fl);
        chk({tag, ".empty"},        empty,        e.em);
        chk({tag, ".almost_full"},  almost_full,  e.af);
        chk({tag, ".almost_empty"}, almost_empty, e.ae);
        chk({tag, ".overflow"},     overflow,     e.ov);
        chk({tag, ".underflow"},    underflow,    e.un);
    endtask

    // One clock of stimulus. Entered 1 time unit after a rising edge; returns
    // 1 time unit after the next rising edge.
    task automatic step(input string tag, input logic wr, input logic rd, input logic clr);
        bit   ew, er;
        exp_t e;
        wr_req  = wr;
        rd_req  = rd;
        clr_err = clr;
        #1;
        ew = wr && (m_cnt != DEPTH);
        er = rd && (m_cnt != 0);
        chk({tag, ".wen"}, wen, ew);
        chk({tag, ".ren"}, ren, er);
        m_ov  = (wr && (m_cnt == DEPTH)) || (m_ov && !clr);
        m_un  = (rd && (m_cnt == 0))     || (m_un && !clr);
        m_cnt = m_cnt + int'(ew) - int'(er);
        m_wa  = (m_wa + int'(ew)) % DEPTH;
        m_ra  = (m_ra + int'(er)) % DEPTH;
        sb.push_back(model_now(er));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk_state(tag, e);
        end
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wa = 0; m_ra = 0; m_ov = 0; m_un = 0;
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held from time 0 with both requests active: no strobes allowed.
        rst_n = 1'b0; wr_req = 1'b1; rd_req = 1'b1; clr_err = 1'b0;
        #1;
        chk("rst0.wen", wen, 1'b0);
        chk("rst0.ren", ren, 1'b0);
        chk_state("rst0", model_now(1'b0));
        @(posedge clk); #1;
        chk_state("rst1", model_now(1'b0));
        wr_req = 1'b0; rd_req = 1'b0;
        rst_n  = 1'b1;

        // Fill from reset: first write honoured on the first edge.
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0);

        // Write while full: rejected, overflow sets; clr in same edge as set.
        step("ovf", 1, 0, 0);
        step("ovf_clr_same", 1, 0, 1);
        step("ovf_clr", 0, 0, 1);

        // Full with both requests: only the read is taken.
        step("full_both", 1, 1, 0);

        // Drain to empty, then read while empty.
        for (int i = 0; i < DEPTH - 1; i++) step("drain", 0, 1, 0);
        step("unf", 0, 1, 0);
        step("unf_hold", 0, 0, 0);
        step("unf_clr", 0, 0, 1);

        // Empty with both requests: only the write is taken.
        step("empty_both", 1, 1, 0);
        step("mid_both", 1, 1, 0);
        step("drain1", 0, 1, 0);

        // 20 interleaved writes and reads: both pointers wrap.
        for (int i = 0; i < 20; i++) begin
            step("ilv_wr", 1, 0, 0);
            step("ilv_rd", 0, 1, 0);
        end

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0));
        end

        // Bring occupancy to 9, then reset between edges.
        step("clr", 0, 0, 1);
        while (m_cnt > 9) step("to9_rd", 0, 1, 0);
        while (m_cnt < 9) step("to9_wr", 1, 0, 0);
        chk("pre_rst.count", count, 5'd9);
        #2;
        wr_req = 1'b1;
        rst_n  = 1'b0;
        model_reset();
        #1;
        chk("async_rst.wen", wen, 1'b0);
        chk_state("async_rst", model_now(1'b0));
        @(posedge clk); #1;
        chk_state("async_rst_hold", model_now(1'b0));
        wr_req = 1'b0;
        rst_n  = 1'b1;
        step("post_rst_wr", 1, 0, 0);
        step("post_rst_rd", 0, 1, 0);
        step("post_rst_idle", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
